debug_frame_source: RTL

Debug stream generator that builds Avalon-ST frames from board switches and keys and drives them onto an `avln_st` output, in place of a real upstream source. It is the transmit-side counterpart of the on-board frame capture/display sink: the sink selects and shows one word of a received stream, and this block produces known, switch-configured frames for that sink or any other `avln_st` consumer. Board-level debug only. It sits at the head of a stream path under test.

---
 rtl/debug_frame_source.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/debug_frame_source.sv
// Switch/key driven Avalon-ST frame generator for board-level stream debug.
// Frames are built from latched SW settings; a frame counter is shown on hex_disp.

module hex_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  // Active-low segments, bit order gfedcba
  always_comb begin
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      default: o_seg = 7'h0E;
    endcase
  end
endmodule

module debug_frame_source #(
  parameter int B   = 8,
  parameter int BpW = 4,
  parameter int GAP = 4
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  output logic                       out_valid,
  output logic [B*BpW-1:0]           out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [$clog2(BpW)-1:0]     out_empty,
  input  logic                       ready,
  input  logic [17:0]                SW,
  input  logic [3:0]                 KEY,
  output logic [7:0]                 LEDG,
  output logic [2*BpW-1:0][6:0]      hex_disp
);
  localparam int DW = B * BpW;
  localparam int EW = $clog2(BpW);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [2:0]    r_sync1, r_sync2, r_sync_d;
  logic [1:0]    r_state;
  logic [15:0]   r_len, r_nw, r_w;
  logic [1:0]    r_pat;
  logic [DW-1:0] r_gcnt, r_fcnt;
  logic [GW-1:0] r_gap;
  logic          r_mode, r_lerr;

  logic [2:0]    w_fall;
  logic          w_clr, w_trig, w_tog, w_mode_nx, w_go, w_start, w_err, w_last;
  logic [16:0]   w_sw_n17;
  logic [15:0]   w_ld_w, w_ld_len, w_ld_nw, w_neg_len;
  logic [1:0]    w_ld_pat;
  logic [DW-1:0] w_ld_g, w_ld_data;
  logic          w_ld_sop, w_ld_eop;
  logic [EW-1:0] w_ld_empty;
  logic          w_unused_key0;

  assign w_unused_key0 = KEY[0];

  // Counter patterns carry the whole value; only the byte-ramp pattern blanks lanes past L.
  function automatic logic [DW-1:0] word_data(input logic [1:0] pat, input logic [15:0] w,
                                             input logic [15:0] len, input logic [DW-1:0] g);
    logic [DW-1:0] d;
    logic [31:0]   bi;
    d = '0;
    case (pat)
      2'b01: d = g;
      2'b10: begin
        for (int j = 0; j < BpW; j++) begin
          bi = {16'd0, w} * 32'(BpW) + 32'(j);
          if (bi < {16'd0, len}) d[DW-1-B*j -: B] = bi[B-1:0];
        end
      end
      default: d = DW'(w);
    endcase
    return d;
  endfunction

  // Key synchronizers; reset value 0 reads as "pressed" so no edge fires until a release
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync1  <= KEY[3:1];
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_fall    = r_sync_d & ~r_sync2;
  assign w_clr     = w_fall[0];
  assign w_trig    = w_fall[1];
  assign w_tog     = w_fall[2];
  assign w_mode_nx = r_mode ^ w_tog;
  assign w_sw_n17  = ({1'b0, SW[15:0]} + 17'(BpW - 1)) >> EW;
  assign w_last    = (r_w == r_nw - 16'd1);

  assign w_go = ((r_state == S_IDLE) && (w_trig || (w_tog && !r_mode))) ||
                ((r_state == S_GAP) && w_mode_nx && (r_gap == GW'(GAP - 1)));
  assign w_start = w_go && (SW[15:0] != 16'd0);
  assign w_err   = w_go && (SW[15:0] == 16'd0);

  // Next word to present: first word of a new frame, or the successor inside SEND
  always_comb begin
    if (r_state == S_SEND) begin
      w_ld_w   = r_w + 16'd1;
      w_ld_len = r_len;
      w_ld_nw  = r_nw;
      w_ld_pat = r_pat;
      w_ld_g   = r_gcnt + DW'(1);
    end else begin
      w_ld_w   = 16'd0;
      w_ld_len = SW[15:0];
      w_ld_nw  = w_sw_n17[15:0];
      w_ld_pat = SW[17:16];
      w_ld_g   = r_gcnt;
    end
    w_ld_sop   = (w_ld_w == 16'd0);
    w_ld_eop   = (w_ld_w == w_ld_nw - 16'd1);
    w_neg_len  = 16'd0 - w_ld_len;
    w_ld_empty = w_ld_eop ? w_neg_len[EW-1:0] : '0;
    w_ld_data  = word_data(w_ld_pat, w_ld_w, w_ld_len, w_ld_g);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE; r_len <= '0; r_nw <= '0; r_w <= '0; r_pat <= '0;
      r_gcnt <= '0; r_fcnt <= '0; r_gap <= '0; r_mode <= 1'b0; r_lerr <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_sop <= 1'b0; out_eop <= 1'b0; out_empty <= '0;
    end else if (w_clr) begin
      r_state <= S_IDLE; r_len <= '0; r_nw <= '0; r_w <= '0; r_pat <= '0;
      r_gcnt <= '0; r_fcnt <= '0; r_gap <= '0; r_mode <= 1'b0; r_lerr <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_sop <= 1'b0; out_eop <= 1'b0; out_empty <= '0;
    end else begin
      r_mode <= w_mode_nx;
      if (w_err) r_lerr <= 1'b1;
      if (w_start) begin
        r_state   <= S_SEND;
        r_len     <= w_ld_len;
        r_nw      <= w_ld_nw;
        r_pat     <= w_ld_pat;
        r_w       <= w_ld_w;
        out_valid <= 1'b1;
        out_data  <= w_ld_data;
        out_sop   <= w_ld_sop;
        out_eop   <= w_ld_eop;
        out_empty <= w_ld_empty;
      end else begin
        case (r_state)
          S_SEND: begin
            if (ready) begin
              r_gcnt <= r_gcnt + DW'(1);
              if (w_last) begin
                r_fcnt    <= r_fcnt + DW'(1);
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
                out_empty <= '0;
                r_gap     <= '0;
                r_state   <= w_mode_nx ? S_GAP : S_IDLE;
              end else begin
                r_w       <= w_ld_w;
                out_data  <= w_ld_data;
                out_sop   <= w_ld_sop;
                out_eop   <= w_ld_eop;
                out_empty <= w_ld_empty;
              end
            end
          end
          S_GAP: begin
            if (!w_mode_nx || w_err) r_state <= S_IDLE;
            else r_gap <= r_gap + GW'(1);
          end
          S_IDLE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign LEDG = {5'b0, r_lerr, r_mode, (r_state != S_IDLE)};

  for (genvar i = 0; i < 2 * BpW; i++) begin : g_hex
    hex_decoder u_hex (.i_nib(r_fcnt[4*i +: 4]), .o_seg(hex_disp[i]));
  end
endmodule
